// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with line-wide memory refill and write-back.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller #(
   parameter int NUM_LINES      = 32,
   parameter int WORDS_PER_LINE = 8,
   localparam int IW     = $clog2(NUM_LINES),
   localparam int OW     = $clog2(WORDS_PER_LINE),
   localparam int LINE_W = 32 * WORDS_PER_LINE,
   localparam int TAG_W  = 30 - IW - OW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       stat_hits_o,
   output logic [31:0]       stat_misses_o
`endif
);

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t               state_q, state_d;
   logic [NUM_LINES-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];
   logic [31:0]          last_q;

   logic [TAG_W-1:0]  req_tag;
   logic [IW-1:0]     idx;
   logic [OW-1:0]     word;
   logic [LINE_W-1:0] line;
   logic [31:0]       rd_word;
   logic              hit;
   logic              unused_bits;

   assign req_tag     = cpu_addr_i[31 -: TAG_W];
   assign idx         = cpu_addr_i[OW+IW+1:OW+2];
   assign word        = cpu_addr_i[OW+1:2];
   assign unused_bits = ^cpu_addr_i[1:0];

   assign line    = data_q[idx];
   assign rd_word = line[{word, 5'd0} +: 32];
   assign hit     = cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag);

   // Outside a hit the load port keeps showing the last word returned.
   assign cpu_data_o = (state_q == IDLE && hit) ? rd_word : last_q;
   assign mem_data_o = line;

   always_comb begin
      state_d     = state_q;
      cpu_stall_o = 1'b1;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      case (state_q)
         IDLE: begin
            cpu_stall_o = cpu_req_i & ~hit;
            if (cpu_req_i && !hit)
               state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = {tag_q[idx], idx, {(OW+2){1'b0}}};
            if (mem_ack_i) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {req_tag, idx, {(OW+2){1'b0}}};
            if (mem_ack_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (hit) begin
               last_q <= rd_word;
               if (cpu_we_i) dirty_q[idx] <= 1'b1;
            end
            WRITEBACK: if (mem_ack_i) dirty_q[idx] <= 1'b0;
            ALLOCATE: if (mem_ack_i) begin
               valid_q[idx] <= 1'b1;
               dirty_q[idx] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays carry no reset; a reset still blocks the refill write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == IDLE && hit && cpu_we_i)
            data_q[idx][{word, 5'd0} +: 32] <= cpu_data_i;
         else if (state_q == ALLOCATE && mem_ack_i) begin
            data_q[idx] <= mem_data_i;
            tag_q[idx]  <= req_tag;
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hits_q, misses_q;

   // Misses count once, on the cycle the miss leaves IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else if (state_q == IDLE && cpu_req_i) begin
         if (hit) hits_q   <= hits_q + 32'd1;
         else     misses_q <= misses_q + 32'd1;
      end
   end

   assign stat_hits_o   = hits_q;
   assign stat_misses_o = misses_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller: flat word-memory reference plus a tag/valid/dirty table
// predicts load data, stall lengths and memory transactions.
module tb_dcache_controller;
   localparam int LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req_i, cpu_we_i;
   logic [31:0]       cpu_addr_i, cpu_data_i, cpu_data_o;
   logic              cpu_stall_o;
   logic              mem_req_o, mem_we_o;
   logic [31:0]       mem_addr_o;
   logic [LINE_W-1:0] mem_data_o, mem_data_i;
   logic              mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0]       stat_hits_o, stat_misses_o;
`endif

   dcache_controller dut (
      .clk(clk), .rst(rst),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
      , .stat_hits_o(stat_hits_o), .stat_misses_o(stat_misses_o)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int ack_n = 3;
   bit mem_en = 1'b1;
   int s_hit = 0, s_miss = 0;

   logic [LINE_W-1:0] bmem [logic [31:0]];
   logic [31:0]       rw   [logic [31:0]];
   logic [32:0]       txn_q [$];
   bit                mv [32];
   bit                md [32];
   logic [21:0]       mt [32];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] wa);
      return rw.exists(wa) ? rw[wa] : init_word(wa);
   endfunction

   function automatic logic [LINE_W-1:0] read_line(input logic [31:0] la);
      logic [LINE_W-1:0] l;
      if (bmem.exists(la)) return bmem[la];
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w*4));
      return l;
   endfunction

   // Memory: ack in the ack_n-th cycle of a request, then one turnaround cycle before the next.
   initial begin
      int  cnt;
      bit  prev_ack;
      cnt = 0; prev_ack = 0;
      mem_ack_i = 1'b0; mem_data_i = '0;
      forever begin
         @(posedge clk); #2;
         if (!mem_en) begin
            cnt = 0; prev_ack = 0;
         end else begin
            mem_ack_i = 1'b0;
            if (prev_ack) begin
               prev_ack = 0; cnt = 0;
            end else if (mem_req_o) begin
               cnt++;
               if (cnt >= ack_n) begin
                  mem_ack_i = 1'b1; prev_ack = 1;
                  txn_q.push_back({mem_we_o, mem_addr_o});
                  if (mem_we_o) bmem[mem_addr_o] = mem_data_o;
                  else          mem_data_i = read_line(mem_addr_o);
               end
            end else cnt = 0;
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin mv[i] = 0; md[i] = 0; end
      s_hit = 0; s_miss = 0;
   endtask

   task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd, input int n);
      logic [4:0]  ix;
      logic [21:0] tg;
      logic [31:0] wa, vaddr, ev;
      logic [32:0] got;
      bit          miss, wb;
      int          exp_st, st;
      wa = {a[31:2], 2'b00};
      ix = a[9:5];
      tg = a[31:10];
      miss   = !(mv[ix] && mt[ix] == tg);
      wb     = miss && mv[ix] && md[ix];
      vaddr  = {mt[ix], ix, 5'b0};
      exp_st = !miss ? 0 : (wb ? 2*n + 2 : n + 1);
      if (miss) begin s_miss++; mv[ix] = 1; mt[ix] = tg; md[ix] = 0; end
      s_hit++;
      if (we) begin md[ix] = 1; rw[wa] = wd; end
      ev = ref_rd(wa);
      ack_n = n;
      @(posedge clk); #1;
      cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = wd;
      st = 0;
      forever begin
         @(negedge clk);
         if (!cpu_stall_o) break;
         st++;
         if (st > 100) begin chk("stall_timeout", 1, 0); break; end
      end
      chk("stall", st, exp_st);
      if (!we) chk("rdata", cpu_data_o, ev);
      if (wb) begin
         got = txn_q.size() != 0 ? txn_q.pop_front() : '1;
         chk("wb_txn", got, {1'b1, vaddr});
      end
      if (miss) begin
         got = txn_q.size() != 0 ? txn_q.pop_front() : '1;
         chk("rd_txn", got, {1'b0, tg, ix, 5'b0});
      end
      chk("txn_left", txn_q.size(), 0);
      @(posedge clk); #1;
      cpu_req_i = 1'b0;
   endtask

   task automatic chk_stats(input string tag);
`ifdef DCACHE_STATS_EN
      chk({tag, "_hits"}, stat_hits_o, s_hit);
      chk({tag, "_misses"}, stat_misses_o, s_miss);
`else
      n_cmp += 0;
`endif
   endtask

   initial begin
      rst = 1'b1; cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_stall", cpu_stall_o, 0);
      chk("rst_mreq", mem_req_o, 0);
      chk("rst_mwe", mem_we_o, 0);
      chk("rst_maddr", mem_addr_o, 0);
      chk("rst_rdata", cpu_data_o, 0);

      access(0, 32'h0000_0040, 0, 3);
      access(1, 32'h0000_0044, 32'hDEAD_BEEF, 3);
      access(0, 32'h0000_0044, 0, 3);
      access(0, 32'h0000_2040, 0, 3);
      chk("wb_word1", bmem.exists(32'h40) ? bmem[32'h40][63:32] : 32'h0, 32'hDEAD_BEEF);
      chk_stats("t6");

      // Stray ack while idle must not touch any line.
      mem_en = 0;
      @(posedge clk); #1 mem_ack_i = 1'b1; mem_data_i = {8{$urandom()}};
      @(negedge clk);
      chk("idle_ack_mreq", mem_req_o, 0);
      chk("idle_ack_stall", cpu_stall_o, 0);
      @(posedge clk); #1 mem_ack_i = 1'b0;
      mem_en = 1;
      access(0, 32'h0000_2044, 0, 2);

      // Reset during ALLOCATE, ack arrives the following cycle.
      mem_en = 0;
      @(posedge clk); #1 cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h40;
      @(negedge clk);
      chk("t4_miss_stall", cpu_stall_o, 1);
      @(negedge clk);
      chk("t4_alloc_req", {mem_req_o, mem_we_o, mem_addr_o}, {2'b10, 32'h40});
      @(posedge clk); #1 rst = 1; cpu_req_i = 0;
      @(posedge clk); #1 rst = 0; mem_ack_i = 1; mem_data_i = {8{$urandom()}};
      @(negedge clk);
      chk("t4_req_after_rst", mem_req_o, 0);
      @(posedge clk); #1 mem_ack_i = 0;
      model_reset();
      // Reset and ack together: reset wins.
      @(posedge clk); #1 cpu_req_i = 1; cpu_addr_i = 32'h40;
      @(posedge clk); @(posedge clk); #1
      rst = 1; mem_ack_i = 1; cpu_req_i = 0; mem_data_i = {8{$urandom()}};
      @(posedge clk); #1 rst = 0; mem_ack_i = 0;
      @(negedge clk);
      chk("rst_ack_mreq", mem_req_o, 0);
      mem_en = 1;
      access(0, 32'h0000_0040, 0, 2);
      access(0, 32'h0000_0048, 0, 1);

      for (int i = 0; i < 250; i++) begin
         logic [31:0] a;
         a = {20'(0), 2'($urandom_range(0, 3)), 5'($urandom()), 3'($urandom()), 2'($urandom())};
         access($urandom_range(0, 9) < 4, a, $urandom(), $urandom_range(1, 4));
      end
      chk_stats("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
